// File: rtl/ahb5_pkg.sv
// ahb5_pkg: shared AHB5 encodings for the bus arbiter slice.
//   htrans_t     - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_t     - HBURST encodings (SINGLE .. INCR16)
//   lock_state_t - burst lock FSM states
//   burst_beats  - beat count of a fixed-length burst, 0 for SINGLE/INCR
package ahb5_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  function automatic logic [4:0] burst_beats(hburst_t burst);
    case (burst)
      WRAP4,  INCR4:  return 5'd4;
      WRAP8,  INCR8:  return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb5_rr_arbiter.sv
// ahb5_rr_arbiter: combinational round-robin pick.
//   req_i   - request vector, one bit per manager
//   ptr_i   - index with highest priority this round
//   valid_o - at least one request present
//   idx_o   - first requesting index at or after ptr_i, modulo NUM_MST
module ahb5_rr_arbiter #(
  parameter int NUM_MST = 2,
  parameter int IDX_W   = $clog2(NUM_MST)
) (
  input  logic [NUM_MST-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  int cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    // Walk from the farthest candidate back to ptr_i so the nearest
    // requester is the last (winning) assignment.
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      cand = int'(ptr_i) + k;
      if (cand >= NUM_MST) cand = cand - NUM_MST;
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ahb5_bus_arbiter.sv
// ahb5_bus_arbiter: shares one AHB5 manager port between NUM_MST requesters.
// Round-robin arbitration at transfer/burst boundaries; fixed-length bursts
// and INCR bursts hold the bus until done. Address-phase owner (owner) and
// data-phase owner (downer) are tracked separately to keep pipelining.
//   HCLK, HRESETn (sync, active-low)
//   m_*       - per-manager request side (address/control/wdata in,
//               grant/ready/resp/rdata out)
//   H*        - single subordinate-side AHB5 bus
module ahb5_bus_arbiter
  import ahb5_pkg::*;
#(
  parameter int NUM_MST = 2
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        m_req    [NUM_MST],
  input  logic [31:0] m_haddr  [NUM_MST],
  input  logic [31:0] m_hwdata [NUM_MST],
  input  logic        m_hwrite [NUM_MST],
  input  logic [2:0]  m_hsize  [NUM_MST],
  input  logic [2:0]  m_hburst [NUM_MST],
  input  logic [3:0]  m_hprot  [NUM_MST],
  input  logic [1:0]  m_htrans [NUM_MST],
  output logic        m_hgrant [NUM_MST],
  output logic        m_hready [NUM_MST],
  output logic        m_hresp  [NUM_MST],
  output logic [31:0] m_hrdata [NUM_MST],
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam int IDX_W = $clog2(NUM_MST);

  logic [IDX_W-1:0]   owner_q, owner_d, downer_q, downer_d, rr_ptr_q, rr_ptr_d;
  logic               dvalid_q, dvalid_d;
  lock_state_t        lock_q, lock_d;
  logic [3:0]         beats_q, beats_d;
  logic [NUM_MST-1:0] grant_q, grant_d;

  logic [NUM_MST-1:0] req_vec;
  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;
  htrans_t            htrans_bus;
  hburst_t            hburst_bus;
  logic               accepted;
  logic [4:0]         nbeats;

  ahb5_rr_arbiter #(.NUM_MST(NUM_MST), .IDX_W(IDX_W)) u_rr (
    .req_i   (req_vec),
    .ptr_i   (rr_ptr_q),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  // Address-phase mux, driven by the registered owner.
  assign HADDR      = m_haddr[owner_q];
  assign HWRITE     = m_hwrite[owner_q];
  assign HSIZE      = m_hsize[owner_q];
  assign HPROT      = m_hprot[owner_q];
  assign hburst_bus = hburst_t'(m_hburst[owner_q]);
  assign HBURST     = hburst_bus;
  assign htrans_bus = (HRESETn && m_req[owner_q]) ? htrans_t'(m_htrans[owner_q]) : IDLE;
  assign HTRANS     = htrans_bus;
  assign HWDATA     = m_hwdata[downer_q];

  assign accepted = HREADY && (htrans_bus == NONSEQ || htrans_bus == SEQ);
  assign nbeats   = burst_beats(hburst_bus);

  always_comb begin
    for (int i = 0; i < NUM_MST; i++) begin
      req_vec[i]  = m_req[i];
      m_hgrant[i] = grant_q[i];
      m_hrdata[i] = HRDATA;
      m_hready[i] = HREADY && ((owner_q == IDX_W'(i)) ||
                               (dvalid_q && downer_q == IDX_W'(i)));
      m_hresp[i]  = HRESP && dvalid_q && (downer_q == IDX_W'(i));
    end
  end

  always_comb begin
    owner_d  = owner_q;
    downer_d = downer_q;
    dvalid_d = dvalid_q;
    lock_d   = lock_q;
    beats_d  = beats_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;

    if (!HREADY) begin
      // First error cycle of the owner's own data phase aborts the burst so
      // the bus can be handed over once the two-cycle response completes.
      if (HRESP && dvalid_q && downer_q == owner_q) begin
        lock_d  = UNLOCKED;
        beats_d = '0;
      end
    end else begin
      dvalid_d = accepted;
      if (accepted) downer_d = owner_q;

      case (lock_q)
        UNLOCKED: begin
          if (accepted && htrans_bus == NONSEQ) begin
            if (nbeats != 5'd0) begin
              lock_d  = LOCKED;
              beats_d = 4'(nbeats - 5'd1);
            end else if (hburst_bus == INCR) begin
              lock_d  = LOCKED;
              beats_d = '0;
            end
          end
        end
        LOCKED: begin
          // beats_q == 0 while locked marks an undefined-length INCR burst.
          if (beats_q == '0) begin
            if (htrans_bus == IDLE) lock_d = UNLOCKED;
          end else if (accepted && htrans_bus == SEQ) begin
            beats_d = beats_q - 4'd1;
            if (beats_q == 4'd1) lock_d = UNLOCKED;
          end
        end
        default: lock_d = UNLOCKED;
      endcase

      if (lock_d == UNLOCKED && arb_valid) begin
        owner_d  = arb_idx;
        rr_ptr_d = (arb_idx == IDX_W'(NUM_MST - 1)) ? '0 : arb_idx + IDX_W'(1);
        grant_d  = '0;
        grant_d[arb_idx] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      owner_q  <= '0;
      downer_q <= '0;
      dvalid_q <= 1'b0;
      lock_q   <= UNLOCKED;
      beats_q  <= '0;
      rr_ptr_q <= '0;
      grant_q  <= NUM_MST'(1);
    end else begin
      owner_q  <= owner_d;
      downer_q <= downer_d;
      dvalid_q <= dvalid_d;
      lock_q   <= lock_d;
      beats_q  <= beats_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

endmodule

// File: tb/tb_ahb5_bus_arbiter.sv
// tb_ahb5_bus_arbiter: directed, self-checking bench for ahb5_bus_arbiter
// with two managers driven from hand-written per-cycle vectors.
module tb_ahb5_bus_arbiter;

  localparam int N = 2;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'b000;
  localparam logic [2:0] B_WRAP4  = 3'b010;
  localparam logic [2:0] B_INCR4  = 3'b011;
  localparam logic [2:0] B_INCR8  = 3'b101;
  localparam logic [2:0] B_INCR16 = 3'b111;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        m_req    [N];
  logic [31:0] m_haddr  [N];
  logic [31:0] m_hwdata [N];
  logic        m_hwrite [N];
  logic [2:0]  m_hsize  [N];
  logic [2:0]  m_hburst [N];
  logic [3:0]  m_hprot  [N];
  logic [1:0]  m_htrans [N];
  logic        m_hgrant [N];
  logic        m_hready [N];
  logic        m_hresp  [N];
  logic [31:0] m_hrdata [N];
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  int n_checks = 0;
  int n_errors = 0;

  ahb5_bus_arbiter #(.NUM_MST(N)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m_req(m_req), .m_haddr(m_haddr), .m_hwdata(m_hwdata), .m_hwrite(m_hwrite),
    .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hprot(m_hprot), .m_htrans(m_htrans),
    .m_hgrant(m_hgrant), .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
    .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic mst(input int i, input logic req, input logic [1:0] tr,
                     input logic [2:0] bu, input logic [31:0] a, input logic [31:0] wd);
    m_req[i]    = req;
    m_htrans[i] = tr;
    m_hburst[i] = bu;
    m_haddr[i]  = a;
    m_hwdata[i] = wd;
  endtask

  function automatic logic [1:0] gnt();
    return {m_hgrant[1], m_hgrant[0]};
  endfunction

  initial begin
    HRESETn = 1'b0;
    HREADY  = 1'b1;
    HRESP   = 1'b1;
    HRDATA  = 32'h0;
    for (int i = 0; i < N; i++) begin
      mst(i, 1'b1, T_NS, B_SINGLE, 32'h0, 32'h0);
      m_hsize[i] = 3'd2;
      m_hprot[i] = 4'h3;
    end
    m_hwrite[0] = 1'b1;
    m_hwrite[1] = 1'b0;

    // Reset held 3 cycles with everyone requesting.
    repeat (3) tick();
    check("rst_gnt", gnt(), 2'b01);
    check("rst_htrans", HTRANS, T_IDLE);
    check("rst_hresp0", m_hresp[0], 1'b0);
    check("rst_hresp1", m_hresp[1], 1'b0);

    // Release: manager 0 alone requests (idle), then nobody (parking).
    HRESETn = 1'b1;
    HRESP   = 1'b0;
    mst(0, 1'b1, T_IDLE, B_SINGLE, 32'h0, DEAD);
    mst(1, 1'b0, T_IDLE, B_SINGLE, 32'h0, DEAD);
    #1;
    check("rel_gnt", gnt(), 2'b01);
    tick();
    mst(0, 1'b0, T_IDLE, B_SINGLE, 32'h0, DEAD);
    #1;
    check("park_gnt", gnt(), 2'b01);
    tick();

    // Back-to-back SINGLEs: grants alternate, HWDATA follows one cycle later.
    mst(0, 1'b1, T_NS, B_SINGLE, 32'h1000, DEAD);
    mst(1, 1'b1, T_NS, B_SINGLE, 32'h2000, DEAD);
    #1;
    check("alt0_gnt", gnt(), 2'b01);
    check("alt0_haddr", HADDR, 32'h1000);
    check("alt0_htrans", HTRANS, T_NS);
    check("alt0_hwrite", HWRITE, 1'b1);
    check("alt0_rdy1", m_hready[1], 1'b0);
    tick();
    mst(0, 1'b1, T_NS, B_SINGLE, 32'h1004, 32'hA000);
    mst(1, 1'b1, T_NS, B_SINGLE, 32'h2000, DEAD);
    #1;
    check("alt1_gnt", gnt(), 2'b10);
    check("alt1_haddr", HADDR, 32'h2000);
    check("alt1_hwdata", HWDATA, 32'hA000);
    check("alt1_hwrite", HWRITE, 1'b0);
    check("alt1_rdy0", m_hready[0], 1'b1);
    tick();
    mst(0, 1'b1, T_NS, B_SINGLE, 32'h1004, DEAD);
    mst(1, 1'b1, T_NS, B_SINGLE, 32'h2004, 32'hB000);
    #1;
    check("alt2_gnt", gnt(), 2'b01);
    check("alt2_haddr", HADDR, 32'h1004);
    check("alt2_hwdata", HWDATA, 32'hB000);
    tick();
    mst(0, 1'b1, T_NS, B_SINGLE, 32'h1008, 32'hA004);
    mst(1, 1'b1, T_NS, B_SINGLE, 32'h2004, DEAD);
    #1;
    check("alt3_gnt", gnt(), 2'b10);
    check("alt3_haddr", HADDR, 32'h2004);
    check("alt3_hwdata", HWDATA, 32'hA004);
    tick();

    // INCR4 at 0x100 by manager 0 while manager 1 keeps requesting.
    mst(0, 1'b1, T_NS, B_INCR4, 32'h100, DEAD);
    mst(1, 1'b1, T_NS, B_SINGLE, 32'h3000, 32'hB004);
    #1;
    check("i4_b0_gnt", gnt(), 2'b01);
    check("i4_b0_haddr", HADDR, 32'h100);
    check("i4_b0_hwdata", HWDATA, 32'hB004);
    tick();
    mst(1, 1'b1, T_NS, B_SINGLE, 32'h3000, DEAD);
    for (int k = 1; k < 4; k++) begin
      mst(0, 1'b1, T_SEQ, B_INCR4, 32'h100 + 32'(4 * k), 32'hC000 + 32'(k - 1));
      #1;
      check($sformatf("i4_b%0d_gnt", k), gnt(), 2'b01);
      check($sformatf("i4_b%0d_haddr", k), HADDR, 32'h100 + 32'(4 * k));
      check($sformatf("i4_b%0d_hwdata", k), HWDATA, 32'hC000 + 32'(k - 1));
      tick();
    end
    mst(0, 1'b0, T_IDLE, B_SINGLE, 32'h0, 32'hC003);
    #1;
    check("i4_hand_gnt", gnt(), 2'b10);
    check("i4_hand_haddr", HADDR, 32'h3000);
    check("i4_hand_hwdata", HWDATA, 32'hC003);
    tick();

    // Owner 1 stops requesting: HTRANS forced IDLE, then manager 0 takes over.
    mst(0, 1'b1, T_NS, B_INCR8, 32'h200, DEAD);
    mst(1, 1'b0, T_IDLE, B_SINGLE, 32'h3000, 32'hB300);
    #1;
    check("drop_gnt", gnt(), 2'b10);
    check("drop_htrans", HTRANS, T_IDLE);
    check("drop_hwdata", HWDATA, 32'hB300);
    tick();

    // INCR8 with two wait states on beat 3; manager 1 requesting throughout.
    mst(1, 1'b1, T_NS, B_SINGLE, 32'h4000, DEAD);
    #1;
    check("i8_b0_gnt", gnt(), 2'b01);
    check("i8_b0_haddr", HADDR, 32'h200);
    tick();
    for (int k = 1; k < 8; k++) begin
      mst(0, 1'b1, T_SEQ, B_INCR8, 32'h200 + 32'(4 * k), DEAD);
      if (k == 2) begin
        HREADY = 1'b0;
        repeat (2) begin
          #1;
          check("i8_wait_gnt", gnt(), 2'b01);
          check("i8_wait_haddr", HADDR, 32'h208);
          check("i8_wait_rdy1", m_hready[1], 1'b0);
          tick();
        end
        HREADY = 1'b1;
      end
      #1;
      check($sformatf("i8_b%0d_gnt", k), gnt(), 2'b01);
      check($sformatf("i8_b%0d_haddr", k), HADDR, 32'h200 + 32'(4 * k));
      tick();
    end
    mst(0, 1'b0, T_IDLE, B_SINGLE, 32'h0, DEAD);
    #1;
    check("i8_hand_gnt", gnt(), 2'b10);
    check("i8_hand_haddr", HADDR, 32'h4000);
    tick();

    // WRAP4 by manager 0 with an ERROR response on beat 2's data phase.
    mst(0, 1'b1, T_NS, B_WRAP4, 32'h300, DEAD);
    mst(1, 1'b0, T_IDLE, B_SINGLE, 32'h5000, DEAD);
    #1;
    check("w4_pre_gnt", gnt(), 2'b10);
    tick();
    mst(1, 1'b1, T_NS, B_SINGLE, 32'h5000, DEAD);
    #1;
    check("w4_b0_gnt", gnt(), 2'b01);
    check("w4_b0_haddr", HADDR, 32'h300);
    tick();
    mst(0, 1'b1, T_SEQ, B_WRAP4, 32'h304, DEAD);
    tick();
    mst(0, 1'b1, T_SEQ, B_WRAP4, 32'h308, DEAD);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    #1;
    check("err1_hresp0", m_hresp[0], 1'b1);
    check("err1_hresp1", m_hresp[1], 1'b0);
    check("err1_gnt", gnt(), 2'b01);
    tick();
    HREADY = 1'b1;
    mst(0, 1'b1, T_IDLE, B_WRAP4, 32'h308, DEAD);
    #1;
    check("err2_hresp0", m_hresp[0], 1'b1);
    check("err2_gnt", gnt(), 2'b01);
    tick();

    // Manager 1 granted after the error; it starts an INCR16.
    HRESP  = 1'b0;
    HRDATA = 32'h1234_5678;
    mst(0, 1'b0, T_IDLE, B_SINGLE, 32'h0, DEAD);
    mst(1, 1'b1, T_NS, B_INCR16, 32'h400, DEAD);
    #1;
    check("err_after_gnt", gnt(), 2'b10);
    check("i16_b0_haddr", HADDR, 32'h400);
    check("i16_b0_htrans", HTRANS, T_NS);
    check("hrdata_bcast0", m_hrdata[0], 32'h1234_5678);
    check("hrdata_bcast1", m_hrdata[1], 32'h1234_5678);
    tick();

    // Reset pulsed during beat 2 of the INCR16.
    mst(1, 1'b1, T_SEQ, B_INCR16, 32'h404, DEAD);
    mst(0, 1'b1, T_NS, B_SINGLE, 32'h6000, DEAD);
    #1;
    check("i16_b1_gnt", gnt(), 2'b10);
    check("i16_b1_haddr", HADDR, 32'h404);
    HRESETn = 1'b0;
    #1;
    check("rst_mid_htrans", HTRANS, T_IDLE);
    tick();
    HRESETn = 1'b1;
    mst(0, 1'b1, T_IDLE, B_SINGLE, 32'h6000, DEAD);
    mst(1, 1'b1, T_SEQ, B_INCR16, 32'h408, DEAD);
    #1;
    check("post_rst_gnt", gnt(), 2'b01);
    check("post_rst_htrans", HTRANS, T_IDLE);
    tick();
    mst(0, 1'b0, T_IDLE, B_SINGLE, 32'h0, DEAD);
    #1;
    check("post_rst2_gnt", gnt(), 2'b01);
    tick();
    #1;
    check("post_rst3_gnt", gnt(), 2'b10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
